// File: rtl/regfile_write_buffer.sv
// In-order write-back queue in front of the 32x32 register file.
// Drains one write per cycle and forwards the youngest queued value to both read ports.

module regfile_write_buffer_fwd #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic [DEPTH-1:0][4:0]       ent_reg,
    input  logic [DEPTH-1:0][WIDTH-1:0] ent_data,
    input  logic [PW-1:0]               head,
    input  logic [CW-1:0]               count,
    input  logic [4:0]                  raddr,
    output logic                        hit,
    output logic [WIDTH-1:0]            data
);
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && ent_reg[idx] == raddr && raddr != 5'd0) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end
endmodule

module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [4:0]               In_Register,
    input  logic [WIDTH-1:0]         In_Data,
    input  logic                     Stall,
    output logic                     RegWrite,
    output logic [4:0]               Write_Register,
    output logic [WIDTH-1:0]         Write_Data,
    input  logic [4:0]               Read_Register1,
    input  logic [4:0]               Read_Register2,
    output logic                     Fwd_Hit1,
    output logic                     Fwd_Hit2,
    output logic [WIDTH-1:0]         Fwd_Data1,
    output logic [WIDTH-1:0]         Fwd_Data2,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NUM_PORTS = 2;

    logic [DEPTH-1:0][4:0]       ent_reg;
    logic [DEPTH-1:0][WIDTH-1:0] ent_data;
    logic [PW-1:0]               head, tail;
    logic [CW-1:0]               count;
    logic                        push, pop, nonempty;

    logic [NUM_PORTS-1:0][4:0]       rd_addr;
    logic [NUM_PORTS-1:0]            fwd_hit;
    logic [NUM_PORTS-1:0][WIDTH-1:0] fwd_data;

    assign nonempty = (count != '0);
    assign In_Ready = (count != CW'(DEPTH));
    // Register 0 requests complete the handshake but never occupy a slot.
    assign push     = In_Valid && In_Ready && (In_Register != 5'd0);
    assign RegWrite = nonempty && !Stall;
    assign pop      = RegWrite;

    assign Write_Register = nonempty ? ent_reg[head]  : 5'd0;
    assign Write_Data     = nonempty ? ent_data[head] : '0;
    assign Count          = count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ent_reg  <= '0;
            ent_data <= '0;
        end else begin
            if (push) begin
                ent_reg[tail]  <= In_Register;
                ent_data[tail] <= In_Data;
                tail           <= tail + PW'(1);
            end
            if (pop)
                head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_addr = {Read_Register2, Read_Register1};

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fwd
            regfile_write_buffer_fwd #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fwd (
                .ent_reg  (ent_reg),
                .ent_data (ent_data),
                .head     (head),
                .count    (count),
                .raddr    (rd_addr[p]),
                .hit      (fwd_hit[p]),
                .data     (fwd_data[p])
            );
        end
    endgenerate

    assign Fwd_Hit1  = fwd_hit[0];
    assign Fwd_Hit2  = fwd_hit[1];
    assign Fwd_Data1 = fwd_data[0];
    assign Fwd_Data2 = fwd_data[1];
endmodule

// File: doc/regfile_write_buffer.md
# regfile_write_buffer

Write-side companion to the 32x32 register file: accepts register write-back requests from the datapath through a valid/ready handshake, queues them in a small in-order FIFO and drains one entry per cycle onto the register file write port (RegWrite / Write_Register / Write_Data). While writes are pending it forwards the youngest queued value for the register file's two read addresses, so readers never see stale data. Sits between the execute/memory write-back path and the register file.

## Interface
- DEPTH, 4, number of queued writes; power of two, 2..16
- WIDTH, 32, data width of a register
- Clock  in  1  single clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high
- In_Valid  in  1  write request present
- In_Ready  out  1  buffer can accept a request this cycle
- In_Register  in  5  destination register number
- In_Data  in  WIDTH  value to write
- Stall  in  1  register file write port unavailable this cycle
- RegWrite  out  1  write strobe to register file
- Write_Register  out  5  register number to write
- Write_Data  out  WIDTH  value to write
- Read_Register1, Read_Register2  in  5 each  addresses being read from the register file
- Fwd_Hit1, Fwd_Hit2  out  1 each  queued write matches corresponding read address
- Fwd_Data1, Fwd_Data2  out  WIDTH each  forwarded value; 0 when no hit
- Count  out  clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries {reg[4:0], data[WIDTH-1:0]}, head pointer, tail pointer, occupancy counter; pointers wrap modulo DEPTH.
- Accept: In_Ready = (Count != DEPTH). A request is accepted when In_Valid && In_Ready at posedge.
- Register 0: an accepted request with In_Register == 0 is consumed (handshake completes) but not stored; Count unchanged by it.
- Drain: RegWrite = (Count != 0) && !Stall. Write_Register/Write_Data = head entry whenever Count != 0, else 0. When RegWrite is high at posedge, head advances and Count decrements.
- Simultaneous accept (nonzero register) and drain: both occur; Count unchanged; pointers both advance.
- In_Ready does not look at drain: when full, no accept in that cycle even if a drain occurs.
- Ordering: entries drain strictly in acceptance order; two writes to the same register both reach the register file, older first.
- Forwarding (combinational): for each read port, search valid entries; Fwd_HitN = 1 if any entry's reg equals Read_RegisterN and Read_RegisterN != 0; Fwd_DataN = data of the youngest (closest to tail) matching entry. Requests in flight on In_* this cycle are not forwarded.
- The head entry is still forwarded in the cycle it drains (register file commits at the same edge).

## Timing
- Reset (async, immediate): head = tail = 0, Count = 0, In_Ready = 1, RegWrite = 0, Write_Register = 0, Write_Data = 0, Fwd_Hit1/2 = 0, Fwd_Data1/2 = 0. Reset mid-drain drops all queued entries; no RegWrite is issued for them.
- Latency: request accepted at edge k appears on Write_* during cycle k+1 (earliest RegWrite edge k+1) if buffer was empty and Stall low.
- Throughput: one accept and one drain per cycle sustained.
- Stall high holds head; Write_Register/Write_Data stay stable, RegWrite low.
- In_Ready, RegWrite, Fwd_* are functions of current state and inputs only; no combinational path from In_Valid to In_Ready.

## Test plan
- Reset then single write: In_Register=5, In_Data=32'hDEADBEEF for one cycle -> next cycle RegWrite=1, Write_Register=5, Write_Data=32'hDEADBEEF; following cycle RegWrite=0, Count=0.
- Fill with Stall=1: accept regs 1,2,3,4 (data 10,20,30,40) -> Count=4, In_Ready=0, fifth request held; release Stall -> writes 1,2,3,4 in order on 4 consecutive cycles, fifth accepted once In_Ready=1.
- Register 0: request reg 0 data 99 -> handshake completes, Count stays 0, no RegWrite, Fwd_Hit with Read_Register1=0 stays 0.
- Forwarding youngest: with Stall=1 queue reg 7 = 1 then reg 7 = 2; Read_Register1=7, Read_Register2=8 -> Fwd_Hit1=1, Fwd_Data1=2, Fwd_Hit2=0, Fwd_Data2=0.
- Simultaneous push/pop with pointer wrap: stream 10 back-to-back writes, Stall=0 -> Count never exceeds 1, all 10 appear in order one per cycle, pointers wrap without loss.
- Async reset mid-operation: 3 entries queued, Stall=1, assert Reset between edges -> Count=0, RegWrite=0, In_Ready=1 immediately; no writes after deassertion.
